// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state main memory model.
// Counter width covers the full 1..255 latency range.
package mem_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int CTR_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter for memory latency; saturates at zero.
// Load wins over decrement.
module wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/main_memory.sv
// Main memory with a programmable wait-state latency.
// IDLE latches the request, WAIT counts down, DONE holds until strobe drops.
module main_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  input  logic              LdCtr,
  output logic [DATA_W-1:0] MDataOut,
  output logic              CtrSig,
  output logic              MBusy
);

  localparam logic [CTR_W-1:0] LOAD_VAL =
    CTR_W'(WAIT_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic w_zero;
  logic w_start;
  logic w_reload;
  logic w_dec;
  logic w_access;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Abort beats reload, reload beats completion.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (MStrobe) w_next = WAIT;
      WAIT: begin
        if (!MStrobe)    w_next = IDLE;
        else if (LdCtr)  w_next = WAIT;
        else if (w_zero) w_next = DONE;
      end
      DONE: if (!MStrobe) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_reload = 1'b0;
    w_dec    = 1'b0;
    w_access = 1'b0;
    MBusy    = (r_state == WAIT);
    CtrSig   = (r_state == DONE);
    unique case (r_state)
      IDLE: w_start = MStrobe;
      WAIT: begin
        if (MStrobe) begin
          if (LdCtr)       w_reload = 1'b1;
          else if (w_zero) w_access = 1'b1;
          else             w_dec    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  wait_counter #(
    .W (CTR_W)
  ) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start | w_reload),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_start) begin
      r_rw   <= MRW;
      r_addr <= MAddr;
      r_data <= MDataIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_access && r_rw) begin
      r_dout <= r_mem[r_addr];
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_access && !r_rw) begin
      r_mem[r_addr] <= r_data;
    end
  end

  assign MDataOut = r_dout;

endmodule

// File: tb/tb_main_memory.sv
// Randomized bench for main_memory at WAIT_CYCLES 4 and 1.
// Expected timing comes from an edge-count model of each access.
module tb_main_memory;

  localparam int WC0 = 4;
  localparam int WC1 = 1;

  logic       clk;
  logic [1:0] rst;
  logic [1:0] strb;
  logic [1:0] mrw;
  logic [1:0] ldc;
  logic [7:0] addr [2];
  logic [7:0] din  [2];
  logic [7:0] dout [2];
  logic [1:0] ctr;
  logic [1:0] busy;

  logic [7:0] ref_mem  [2][256];
  bit         ref_ok   [2][256];
  logic [7:0] ref_dout [2];

  int n_cmp;
  int n_err;

  main_memory #(
    .ADDR_W (8), .DATA_W (8), .WAIT_CYCLES (WC0)
  ) u_dut0 (
    .clk (clk), .reset (rst[0]),
    .MStrobe (strb[0]), .MRW (mrw[0]),
    .MAddr (addr[0]), .MDataIn (din[0]),
    .LdCtr (ldc[0]), .MDataOut (dout[0]),
    .CtrSig (ctr[0]), .MBusy (busy[0])
  );

  main_memory #(
    .ADDR_W (8), .DATA_W (8), .WAIT_CYCLES (WC1)
  ) u_dut1 (
    .clk (clk), .reset (rst[1]),
    .MStrobe (strb[1]), .MRW (mrw[1]),
    .MAddr (addr[1]), .MDataIn (din[1]),
    .LdCtr (ldc[1]), .MDataOut (dout[1]),
    .CtrSig (ctr[1]), .MBusy (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? WC0 : WC1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, ".busy"}, 32'(busy[k]), 32'd0);
    chk({tag, ".ctr"},  32'(ctr[k]),  32'd0);
    chk({tag, ".dout"}, 32'(dout[k]), 32'(ref_dout[k]));
  endtask

  // One access: ldp = edge sampling a LdCtr pulse (0 none),
  // abp = edge sampling MStrobe low during WAIT (0 none).
  task automatic access(input int k, input bit rw,
                        input logic [7:0] a,
                        input logic [7:0] d,
                        input int ldp, input int abp);
    int  done;
    bit  aborted;
    done    = (ldp > 0) ? ldp + wc(k) : wc(k);
    aborted = 1'b0;
    strb[k] = 1'b1;
    mrw[k]  = rw;
    addr[k] = a;
    din[k]  = d;
    ldc[k]  = 1'($urandom_range(0, 1));
    step();
    ldc[k]  = 1'b0;
    for (int e = 0; e <= done; e++) begin
      if (abp > 0 && e == abp) begin
        aborted = 1'b1;
        break;
      end
      if (e == done) break;
      chk("wait.busy", 32'(busy[k]), 32'd1);
      chk("wait.ctr",  32'(ctr[k]),  32'd0);
      mrw[k]  = 1'($urandom);
      addr[k] = 8'($urandom);
      din[k]  = 8'($urandom);
      ldc[k]  = (ldp == e + 1);
      if (abp == e + 1) strb[k] = 1'b0;
      step();
    end
    ldc[k] = 1'b0;
    if (aborted) begin
      chk_idle(k, "abort");
    end else begin
      if (rw) ref_dout[k] = ref_mem[k][a];
      else begin
        ref_mem[k][a] = d;
        ref_ok[k][a]  = 1'b1;
      end
      chk("done.ctr",  32'(ctr[k]),  32'd1);
      chk("done.busy", 32'(busy[k]), 32'd0);
      chk("done.dout", 32'(dout[k]), 32'(ref_dout[k]));
      repeat ($urandom_range(0, 2)) begin
        ldc[k] = 1'($urandom);
        step();
        chk("hold.ctr",  32'(ctr[k]),  32'd1);
        chk("hold.busy", 32'(busy[k]), 32'd0);
      end
      strb[k] = 1'b0;
      ldc[k]  = 1'b0;
      step();
      chk_idle(k, "ret");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 2'b11;
    strb  = 2'b00;
    mrw   = 2'b00;
    ldc   = 2'b00;
    for (int k = 0; k < 2; k++) begin
      addr[k]     = '0;
      din[k]      = '0;
      ref_dout[k] = '0;
      for (int i = 0; i < 256; i++) ref_ok[k][i] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) chk_idle(k, "rst");
    step();
    step();
    #3;
    rst = 2'b00;
    step();
    for (int k = 0; k < 2; k++) chk_idle(k, "post_rst");

    // Basic write then read, latency 4.
    access(0, 0, 8'h10, 8'hA5, 0, 0);
    access(0, 1, 8'h10, 8'h00, 0, 0);
    chk("rd_a5", 32'(dout[0]), 32'hA5);

    // Aborted write leaves old contents.
    access(0, 0, 8'hFF, 8'h11, 0, 0);
    access(0, 0, 8'hFF, 8'h3C, 0, 2);
    access(0, 1, 8'hFF, 8'h00, 0, 0);
    chk("abort_ff", 32'(dout[0]), 32'h11);

    // LdCtr in 3rd WAIT cycle pushes completion to edge 7.
    access(0, 1, 8'h10, 8'h00, 3, 0);

    // Reset mid-WAIT discards the write.
    access(0, 0, 8'h00, 8'h5A, 0, 0);
    strb[0] = 1'b1;
    mrw[0]  = 1'b0;
    addr[0] = 8'h00;
    din[0]  = 8'hC3;
    step();
    step();
    #2;
    rst[0] = 1'b1;
    #1;
    ref_dout[0] = '0;
    chk_idle(0, "rst_mid");
    strb[0] = 1'b0;
    step();
    chk_idle(0, "rst_hold");
    rst[0] = 1'b0;
    step();
    access(0, 1, 8'h00, 8'h00, 0, 0);
    chk("rst_keep", 32'(dout[0]), 32'h5A);

    // Latency 1 at both address extremes.
    access(1, 0, 8'h00, 8'h96, 0, 0);
    access(1, 0, 8'hFF, 8'h69, 0, 0);
    access(1, 1, 8'h00, 8'h00, 0, 0);
    access(1, 1, 8'hFF, 8'h00, 0, 0);
    chk("w1_ff", 32'(dout[1]), 32'h69);

    for (int k = 0; k < 2; k++) begin
      repeat (40) begin
        logic [7:0] a;
        bit         rw;
        int         ldp;
        int         abp;
        if ($urandom_range(0, 3) == 0)
          a = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        else
          a = 8'($urandom);
        rw  = 1'($urandom) && ref_ok[k][a];
        ldp = ($urandom_range(0, 3) == 0)
              ? $urandom_range(1, wc(k)) : 0;
        abp = (ldp == 0 && $urandom_range(0, 4) == 0)
              ? $urandom_range(1, wc(k)) : 0;
        access(k, rw, a, 8'($urandom), ldp, abp);
        repeat ($urandom_range(0, 2)) begin
          ldc[k] = 1'($urandom);
          step();
          chk_idle(k, "gap");
        end
        ldc[k] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 8, data word width in bits.
REQ-003 Parameter WAIT_CYCLES, default 4, access latency in clock cycles; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MStrobe  input  1  memory access request from the cache controller; held high until the access completes.
REQ-007 MRW  input  1  access type: 1 = read, 0 = write.
REQ-008 MAddr  input  ADDR_W  word address.
REQ-009 MDataIn  input  DATA_W  write data.
REQ-010 LdCtr  input  1  controller request to reload the wait counter.
REQ-011 MDataOut  output  DATA_W  registered read data.
REQ-012 CtrSig  output  1  access complete / wait count expired.
REQ-013 MBusy  output  1  high while an access is in progress (state WAIT).

Function
REQ-014 The block shall implement a three-state machine: IDLE, WAIT, DONE.
REQ-015 In IDLE with MStrobe=1 at a rising edge, the block shall latch MRW, MAddr and MDataIn, load the counter with WAIT_CYCLES-1, and enter WAIT.
REQ-016 In WAIT, when the counter is nonzero at a rising edge, the block shall decrement the counter by 1.
REQ-017 In WAIT, when the counter is zero at a rising edge, the block shall perform the access and enter DONE.
REQ-018 On a read, MDataOut shall take mem[latched address] on the same edge; on a write, mem[latched address] shall take the latched data and MDataOut shall hold its value.
REQ-019 CtrSig shall be 1 only in DONE, so it first rises exactly WAIT_CYCLES cycles after the edge on which MStrobe was sampled.
REQ-020 MBusy shall be 1 only in WAIT.
REQ-021 In DONE, the block shall stay in DONE while MStrobe=1 and return to IDLE on the first edge with MStrobe=0.
REQ-022 MStrobe=0 sampled in WAIT shall abort the access: next state IDLE, no memory write, MDataOut unchanged.
REQ-023 LdCtr=1 in WAIT shall reload the counter with WAIT_CYCLES-1 and restart the latency; LdCtr shall take priority over decrement and completion.
REQ-024 LdCtr=1 in IDLE or DONE shall have no effect on the state.
REQ-025 When LdCtr and MStrobe are both 1 in IDLE, the block shall start the access normally.
REQ-026 Changes on MRW, MAddr or MDataIn after the IDLE->WAIT edge shall be ignored until the next access.
REQ-027 Every address 0..2^ADDR_W-1 shall be valid with no wrap or aliasing; the counter shall never wrap below zero.
REQ-028 With WAIT_CYCLES=1, the block shall go IDLE->WAIT->DONE, asserting CtrSig one cycle after the strobe edge.

Reset
REQ-029 Assertion of reset shall immediately force state IDLE, counter 0, MDataOut 0, CtrSig 0 and MBusy 0, regardless of clk.
REQ-030 Reset asserted mid-access shall discard the pending access with no memory write.
REQ-031 Memory array contents shall not be cleared by reset.

Structure
REQ-032 Package mem_pkg shall hold the state enum (IDLE, WAIT, DONE) and the default ADDR_W, DATA_W and WAIT_CYCLES constants.
REQ-033 The down-counter shall be the sub-module wait_counter, with load, decrement, zero-flag and asynchronous reset; the storage array and FSM shall remain in main_memory.

Verification
REQ-034 Write 8'hA5 to addr 8'h10 at WAIT_CYCLES=4 -> MBusy high for 4 cycles, CtrSig rises on cycle 4 after the strobe edge, then mem[8'h10]=8'hA5.
REQ-035 Read addr 8'h10 after the write -> MDataOut=8'hA5 in the same cycle CtrSig rises; CtrSig holds until MStrobe drops, then IDLE.
REQ-036 Drop MStrobe after 2 WAIT cycles of a write of 8'h3C to 8'hFF -> return to IDLE with no CtrSig; a subsequent read of 8'hFF does not return 8'h3C.
REQ-037 Pulse LdCtr in the 3rd WAIT cycle -> CtrSig delayed to 4 cycles after the pulse edge (7 total).
REQ-038 Assert reset during WAIT of a write to 8'h00 -> outputs zero immediately, state IDLE, mem[8'h00] unchanged.
REQ-039 WAIT_CYCLES=1 and back-to-back accesses to 8'h00 and 8'hFF -> CtrSig one cycle after each strobe edge, with correct data at both address extremes.
